// File: rtl/bit_dco.sv
// Bit-clock divider: counts oversampling ticks per bit and folds loop-filter
// add/sub pulses into one-tick phase corrections at the bit boundary.
module bit_dco #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         add,
  input  logic         sub,
  output logic         sclk,
  output logic         stb,
  output logic         wrap,
  output logic [W-1:0] phase,
  output logic         ovf
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] HALF = W'(N / 2);

  logic [W-1:0] ph, ph_next;
  logic         pa, ps, held;
  logic         pa_next, ps_next, held_next;
  logic         at_end, take_a, take_s, pa_eff, ps_eff;
  logic         drop, stb_next, wrap_next;

  always_comb begin
    ph_next   = ph;
    held_next = held;
    at_end    = en && (ph == LAST);
    take_a    = at_end && !held && pa;
    take_s    = at_end && !held && !pa && ps;

    if (en) begin
      if (ph != LAST)  ph_next = ph + W'(1);
      else if (held) begin
        ph_next   = '0;
        held_next = 1'b0;
      end
      else if (pa)     ph_next = W'(1);
      else if (ps)     held_next = 1'b1;
      else             ph_next = '0;
    end

    // A pulse landing on the consuming tick is judged against the flags as
    // they will be after consumption, so it queues for the next period.
    pa_eff  = pa && !take_a;
    ps_eff  = ps && !take_s;
    pa_next = pa_eff;
    ps_next = ps_eff;
    drop    = 1'b0;
    if (add && !sub) begin
      if (ps_eff)       ps_next = 1'b0;
      else if (!pa_eff) pa_next = 1'b1;
      else              drop = 1'b1;
    end
    else if (sub && !add) begin
      if (pa_eff)       pa_next = 1'b0;
      else if (!ps_eff) ps_next = 1'b1;
      else              drop = 1'b1;
    end

    stb_next  = en && (ph_next == HALF);
    wrap_next = at_end && !take_s && !(held_next && !held);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph   <= '0;
      pa   <= 1'b0;
      ps   <= 1'b0;
      held <= 1'b0;
      sclk <= 1'b0;
      stb  <= 1'b0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end
    else begin
      ph   <= ph_next;
      pa   <= pa_next;
      ps   <= ps_next;
      held <= held_next;
      sclk <= (ph_next >= HALF);
      stb  <= stb_next;
      wrap <= wrap_next;
      ovf  <= drop;
    end
  end

  assign phase = ph;

endmodule
